// File: rtl/axi4_stream_multiple_upsizer.sv
// axi4_stream_multiple_upsizer: packs RATIO narrow AXI4-Stream beats into one
// wide beat, lane 0 first. A partial word is closed on tlast. Unused lanes carry
// zero tdata/tkeep/tstrb.
// Optional feature: define AXI4_STREAM_UPSIZER_FLUSH_EN to force-close a partial
// word after FLUSH_TIMEOUT idle cycles. The flushed word has tlast=0.
module axi4_stream_multiple_upsizer #(
    parameter int unsigned SLAVE_TDATA_WIDTH  = 32,
    parameter int unsigned MASTER_TDATA_WIDTH = 64,
    parameter int unsigned FLUSH_TIMEOUT      = 16,
    parameter int unsigned TUSER_WIDTH        = 1,
    parameter int unsigned TID_WIDTH          = 8,
    parameter int unsigned TDEST_WIDTH        = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    // narrow slave side
    input  logic                            pkt_i_tvalid,
    output logic                            pkt_i_tready,
    input  logic [SLAVE_TDATA_WIDTH-1:0]    pkt_i_tdata,
    input  logic [SLAVE_TDATA_WIDTH/8-1:0]  pkt_i_tkeep,
    input  logic [SLAVE_TDATA_WIDTH/8-1:0]  pkt_i_tstrb,
    input  logic                            pkt_i_tlast,
    input  logic [TUSER_WIDTH-1:0]          pkt_i_tuser,
    input  logic [TID_WIDTH-1:0]            pkt_i_tid,
    input  logic [TDEST_WIDTH-1:0]          pkt_i_tdest,
    // wide master side
    output logic                            pkt_o_tvalid,
    input  logic                            pkt_o_tready,
    output logic [MASTER_TDATA_WIDTH-1:0]   pkt_o_tdata,
    output logic [MASTER_TDATA_WIDTH/8-1:0] pkt_o_tkeep,
    output logic [MASTER_TDATA_WIDTH/8-1:0] pkt_o_tstrb,
    output logic                            pkt_o_tlast,
    output logic [TUSER_WIDTH-1:0]          pkt_o_tuser,
    output logic [TID_WIDTH-1:0]            pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]          pkt_o_tdest
);

    localparam int unsigned RATIO         = MASTER_TDATA_WIDTH / SLAVE_TDATA_WIDTH;
    localparam int unsigned INS_CNT_WIDTH = $clog2(RATIO);
    localparam int unsigned SKEEP_WIDTH   = SLAVE_TDATA_WIDTH / 8;
    localparam int unsigned MKEEP_WIDTH   = MASTER_TDATA_WIDTH / 8;

    // Elaboration-time guard against unsupported geometry
    if (RATIO < 2 || (MASTER_TDATA_WIDTH % SLAVE_TDATA_WIDTH) != 0 ||
        (SLAVE_TDATA_WIDTH % 8) != 0 || FLUSH_TIMEOUT < 1) begin : g_bad_param
        $error("axi4_stream_multiple_upsizer: unsupported parameter combination");
    end

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [MASTER_TDATA_WIDTH-1:0] data_q, data_d;
    logic [MKEEP_WIDTH-1:0]     keep_q, keep_d;
    logic [MKEEP_WIDTH-1:0]     strb_q, strb_d;
    logic                       last_q, last_d;
    logic [TUSER_WIDTH-1:0]     user_q, user_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic [TDEST_WIDTH-1:0]     dest_q, dest_d;
    logic [INS_CNT_WIDTH-1:0]   ins_pos_q, ins_pos_d;
    logic [INS_CNT_WIDTH-1:0]   wr_pos;
    logic                       wr_en;
    logic                       clr;
    logic                       rx_hs;
    logic                       tx_hs;
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
    localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
    logic [IDLE_W-1:0]          idle_q, idle_d;
`endif

    // Handshakes and ready: accept whenever the output slot is empty or draining
    assign pkt_i_tready = (state_q == ACCUM) | pkt_o_tready;
    assign rx_hs        = pkt_i_tvalid & pkt_i_tready;
    assign tx_hs        = pkt_o_tvalid & pkt_o_tready;

    // Output bus driven straight from the word registers
    assign pkt_o_tvalid = (state_q == HOLD);
    assign pkt_o_tdata  = data_q;
    assign pkt_o_tkeep  = keep_q;
    assign pkt_o_tstrb  = strb_q;
    assign pkt_o_tlast  = last_q;
    assign pkt_o_tuser  = user_q;
    assign pkt_o_tid    = id_q;
    assign pkt_o_tdest  = dest_q;

    // State and word registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ACCUM;
            data_q    <= '0;
            keep_q    <= '0;
            strb_q    <= '0;
            last_q    <= 1'b0;
            user_q    <= '0;
            id_q      <= '0;
            dest_q    <= '0;
            ins_pos_q <= '0;
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            strb_q    <= strb_d;
            last_q    <= last_d;
            user_q    <= user_d;
            id_q      <= id_d;
            dest_q    <= dest_d;
            ins_pos_q <= ins_pos_d;
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
            idle_q    <= idle_d;
`endif
        end
    end

    // Next-state: decide clear/write, then apply buffer clear before the lane write
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        keep_d    = keep_q;
        strb_d    = strb_q;
        last_d    = last_q;
        user_d    = user_q;
        id_d      = id_q;
        dest_d    = dest_q;
        ins_pos_d = ins_pos_q;
        wr_pos    = '0;
        wr_en     = 1'b0;
        clr       = 1'b0;
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
        idle_d    = idle_q;
`endif
        case (state_q)
            ACCUM: begin
                if (rx_hs) begin
                    wr_en  = 1'b1;
                    wr_pos = ins_pos_q;
                    if (ins_pos_q == INS_CNT_WIDTH'(RATIO - 1) || pkt_i_tlast) begin
                        state_d   = HOLD;
                        last_d    = pkt_i_tlast;
                        ins_pos_d = '0;
                    end else begin
                        ins_pos_d = ins_pos_q + INS_CNT_WIDTH'(1);
                    end
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
                    idle_d = '0;
                end else if (ins_pos_q != '0) begin
                    if (idle_q == IDLE_W'(FLUSH_TIMEOUT)) begin
                        state_d   = HOLD;
                        last_d    = 1'b0;
                        ins_pos_d = '0;
                        idle_d    = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
`endif
                end
            end
            HOLD: begin
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
                idle_d = '0;
`endif
                if (tx_hs) begin
                    clr     = 1'b1;
                    last_d  = 1'b0;
                    state_d = ACCUM;
                    if (rx_hs) begin
                        wr_en  = 1'b1;
                        wr_pos = '0;
                        if (pkt_i_tlast) begin
                            state_d = HOLD;
                            last_d  = 1'b1;
                        end else begin
                            ins_pos_d = INS_CNT_WIDTH'(1);
                        end
                    end
                end
            end
            default: state_d = ACCUM;
        endcase

        if (clr) begin
            data_d = '0;
            keep_d = '0;
            strb_d = '0;
        end
        if (wr_en) begin
            for (int unsigned l = 0; l < RATIO; l++) begin
                if (wr_pos == INS_CNT_WIDTH'(l)) begin
                    data_d[l*SLAVE_TDATA_WIDTH +: SLAVE_TDATA_WIDTH] = pkt_i_tdata;
                    keep_d[l*SKEEP_WIDTH +: SKEEP_WIDTH]             = pkt_i_tkeep;
                    strb_d[l*SKEEP_WIDTH +: SKEEP_WIDTH]             = pkt_i_tstrb;
                end
            end
            if (wr_pos == '0) begin
                user_d = pkt_i_tuser;
                id_d   = pkt_i_tid;
                dest_d = pkt_i_tdest;
            end
        end
    end

endmodule

// File: tb/tb_axi4_stream_multiple_upsizer.sv
// tb_axi4_stream_multiple_upsizer: directed stimulus with a scoreboard queue of
// expected wide beats; a negedge monitor pops and compares on every output handshake.
// Honors AXI4_STREAM_UPSIZER_FLUSH_EN for the idle-flush scenario.
module tb_axi4_stream_multiple_upsizer;

    localparam int unsigned SW  = 32;
    localparam int unsigned MW  = 64;
    localparam int unsigned FT  = 16;
    localparam int unsigned UW  = 1;
    localparam int unsigned IW  = 8;
    localparam int unsigned DW  = 4;
    localparam int unsigned SKW = SW / 8;
    localparam int unsigned MKW = MW / 8;

    logic           clk;
    logic           rst;
    logic           pkt_i_tvalid;
    logic           pkt_i_tready;
    logic [SW-1:0]  pkt_i_tdata;
    logic [SKW-1:0] pkt_i_tkeep;
    logic [SKW-1:0] pkt_i_tstrb;
    logic           pkt_i_tlast;
    logic [UW-1:0]  pkt_i_tuser;
    logic [IW-1:0]  pkt_i_tid;
    logic [DW-1:0]  pkt_i_tdest;
    logic           pkt_o_tvalid;
    logic           pkt_o_tready;
    logic [MW-1:0]  pkt_o_tdata;
    logic [MKW-1:0] pkt_o_tkeep;
    logic [MKW-1:0] pkt_o_tstrb;
    logic           pkt_o_tlast;
    logic [UW-1:0]  pkt_o_tuser;
    logic [IW-1:0]  pkt_o_tid;
    logic [DW-1:0]  pkt_o_tdest;

    typedef struct {
        logic [MW-1:0]  data;
        logic [MKW-1:0] keep;
        logic           last;
        logic [IW-1:0]  id;
    } exp_t;

    exp_t exp_q[$];
    time  out_time_q[$];
    time  acc_time;
    time  first_acc;
    int   n_checks;
    int   n_errors;

    logic           prev_v, prev_r, prev_l;
    logic [MW-1:0]  prev_d;
    logic [MKW-1:0] prev_k;

    axi4_stream_multiple_upsizer #(
        .SLAVE_TDATA_WIDTH (SW),
        .MASTER_TDATA_WIDTH(MW),
        .FLUSH_TIMEOUT     (FT),
        .TUSER_WIDTH       (UW),
        .TID_WIDTH         (IW),
        .TDEST_WIDTH       (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pkt_i_tvalid(pkt_i_tvalid),
        .pkt_i_tready(pkt_i_tready),
        .pkt_i_tdata (pkt_i_tdata),
        .pkt_i_tkeep (pkt_i_tkeep),
        .pkt_i_tstrb (pkt_i_tstrb),
        .pkt_i_tlast (pkt_i_tlast),
        .pkt_i_tuser (pkt_i_tuser),
        .pkt_i_tid   (pkt_i_tid),
        .pkt_i_tdest (pkt_i_tdest),
        .pkt_o_tvalid(pkt_o_tvalid),
        .pkt_o_tready(pkt_o_tready),
        .pkt_o_tdata (pkt_o_tdata),
        .pkt_o_tkeep (pkt_o_tkeep),
        .pkt_o_tstrb (pkt_o_tstrb),
        .pkt_o_tlast (pkt_o_tlast),
        .pkt_o_tuser (pkt_o_tuser),
        .pkt_o_tid   (pkt_o_tid),
        .pkt_o_tdest (pkt_o_tdest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input logic [MW-1:0] d, input logic [MKW-1:0] k,
                               input logic l, input logic [IW-1:0] id);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    // Present one narrow beat (called at posedge+1) and return at posedge+1 after acceptance
    task automatic send(input logic [SW-1:0] d, input logic [SKW-1:0] k,
                        input logic l, input logic [IW-1:0] id);
        bit acc;
        pkt_i_tvalid = 1'b1;
        pkt_i_tdata  = d;
        pkt_i_tkeep  = k;
        pkt_i_tstrb  = k;
        pkt_i_tlast  = l;
        pkt_i_tid    = id;
        pkt_i_tuser  = id[0];
        pkt_i_tdest  = id[3:0];
        acc = 1'b0;
        for (int b = 0; b < 200 && !acc; b++) begin
            @(negedge clk);
            acc = pkt_i_tready;
            @(posedge clk);
            acc_time = $time;
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: beat %h never accepted, required acceptance", d);
        end
    endtask

    task automatic idle_in();
        pkt_i_tvalid = 1'b0;
        pkt_i_tlast  = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty
    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: output handshake compare, stall stability, backpressure on the input
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 64'(pkt_o_tvalid), 64'd1);
                chk("hold_data", pkt_o_tdata, prev_d);
                chk("hold_keep", 64'(pkt_o_tkeep), 64'(prev_k));
                chk("hold_last", 64'(pkt_o_tlast), 64'(prev_l));
            end
            if (pkt_o_tvalid && !pkt_o_tready)
                chk("stall_in_ready", 64'(pkt_i_tready), 64'd0);
            if (pkt_o_tvalid && pkt_o_tready) begin
                out_time_q.push_back($time);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got data %h, expected no beat", pkt_o_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", pkt_o_tdata, e.data);
                    chk("out_keep", 64'(pkt_o_tkeep), 64'(e.keep));
                    chk("out_strb", 64'(pkt_o_tstrb), 64'(e.keep));
                    chk("out_last", 64'(pkt_o_tlast), 64'(e.last));
                    chk("out_id", 64'(pkt_o_tid), 64'(e.id));
                    chk("out_user", 64'(pkt_o_tuser), 64'(e.id[0]));
                    chk("out_dest", 64'(pkt_o_tdest), 64'(e.id[3:0]));
                end
            end
        end
        prev_v = rst ? 1'b0 : pkt_o_tvalid;
        prev_r = pkt_o_tready;
        prev_d = pkt_o_tdata;
        prev_k = pkt_o_tkeep;
        prev_l = pkt_o_tlast;
    end

    initial begin
        int base;
        int n0;
        n_checks     = 0;
        n_errors     = 0;
        prev_v       = 1'b0;
        rst          = 1'b1;
        pkt_o_tready = 1'b1;
        pkt_i_tvalid = 1'b0;
        pkt_i_tdata  = '0;
        pkt_i_tkeep  = '0;
        pkt_i_tstrb  = '0;
        pkt_i_tlast  = 1'b0;
        pkt_i_tuser  = '0;
        pkt_i_tid    = '0;
        pkt_i_tdest  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", 64'(pkt_o_tvalid), 64'd0);
        chk("reset_tdata", pkt_o_tdata, 64'd0);
        chk("reset_tkeep", 64'(pkt_o_tkeep), 64'd0);
        chk("reset_tlast", 64'(pkt_o_tlast), 64'd0);
        chk("reset_in_ready", 64'(pkt_i_tready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Two beats closed by tlast; id taken from lane 0
        expect_beat(64'h22222222_11111111, 8'hFF, 1'b1, 8'h11);
        send(32'h11111111, 4'hF, 1'b0, 8'h11);
        send(32'h22222222, 4'hF, 1'b1, 8'h99);
        idle_in();
        drain();

        // Three beats: full word, then partial word closed by tlast
        expect_beat(64'hBBBBBBBB_AAAAAAAA, 8'hFF, 1'b0, 8'h02);
        expect_beat(64'h00000000_CCCCCCCC, 8'h0F, 1'b1, 8'h03);
        send(32'hAAAAAAAA, 4'hF, 1'b0, 8'h02);
        send(32'hBBBBBBBB, 4'hF, 1'b0, 8'h05);
        send(32'hCCCCCCCC, 4'hF, 1'b1, 8'h03);
        idle_in();
        drain();

        // Backpressure: word held while sink stalls, next beat waits then joins
        expect_beat(64'h0000B002_0000A001, 8'hFF, 1'b0, 8'h21);
        expect_beat(64'h0000D004_0000C003, 8'hFF, 1'b1, 8'h23);
        pkt_o_tready = 1'b0;
        fork
            begin
                send(32'h0000A001, 4'hF, 1'b0, 8'h21);
                send(32'h0000B002, 4'hF, 1'b0, 8'h22);
                send(32'h0000C003, 4'hF, 1'b0, 8'h23);
                send(32'h0000D004, 4'hF, 1'b1, 8'h24);
                idle_in();
            end
            begin
                repeat (7) @(posedge clk);
                #1 pkt_o_tready = 1'b1;
            end
        join
        drain();

        // Zero-keep beat is packed as-is
        expect_beat(64'hCAFE0001_00000005, 8'h30, 1'b1, 8'h01);
        send(32'h00000005, 4'h0, 1'b0, 8'h01);
        send(32'hCAFE0001, 4'h3, 1'b1, 8'h06);
        idle_in();
        drain();

        // Continuous streaming: 100 beats, one per cycle in, one wide beat per two cycles out
        base = out_time_q.size();
        for (int i = 0; i < 100; i += 2)
            expect_beat({32'h10000000 + 32'(i + 1), 32'h10000000 + 32'(i)}, 8'hFF,
                        (i == 98), IW'(i));
        for (int i = 0; i < 100; i++) begin
            send(32'h10000000 + 32'(i), 4'hF, (i == 99), IW'(i));
            if (i == 0) first_acc = acc_time;
        end
        idle_in();
        chk("stream_in_rate", 64'(acc_time - first_acc), 64'd990);
        drain();
        chk("stream_count", 64'(out_time_q.size() - base), 64'd50);
        if (out_time_q.size() >= base + 50)
            chk("stream_out_rate", 64'(out_time_q[base+49] - out_time_q[base]), 64'd980);

        // Reset mid-word discards the partial word
        send(32'hDEADBEEF, 4'hF, 1'b0, 8'h07);
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tvalid", 64'(pkt_o_tvalid), 64'd0);
        chk("rst_mid_in_ready", 64'(pkt_i_tready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_beat(64'h55550002_55550001, 8'hFF, 1'b1, 8'h09);
        send(32'h55550001, 4'hF, 1'b0, 8'h09);
        send(32'h55550002, 4'hF, 1'b1, 8'h04);
        idle_in();
        drain();

        // Lone beat followed by idle
        n0 = out_time_q.size();
`ifdef AXI4_STREAM_UPSIZER_FLUSH_EN
        expect_beat(64'h00000000_AAAAAAAA, 8'h0F, 1'b0, 8'h0A);
        send(32'hAAAAAAAA, 4'hF, 1'b0, 8'h0A);
        idle_in();
        for (int c = 0; c < 100 && out_time_q.size() == n0; c++) @(posedge clk);
        #1;
        chk("flush_count", 64'(out_time_q.size() - n0), 64'd1);
        if (out_time_q.size() > n0)
            chk("flush_latency", 64'(out_time_q[n0] - acc_time), 64'((FT + 1) * 10 + 5));
        expect_beat(64'h00000000_BBBBBBBB, 8'h0F, 1'b1, 8'h0B);
        send(32'hBBBBBBBB, 4'hF, 1'b1, 8'h0B);
`else
        send(32'hAAAAAAAA, 4'hF, 1'b0, 8'h0A);
        idle_in();
        repeat (40) @(posedge clk);
        #1;
        chk("no_flush", 64'(out_time_q.size() - n0), 64'd0);
        chk("no_flush_valid", 64'(pkt_o_tvalid), 64'd0);
        expect_beat(64'hBBBBBBBB_AAAAAAAA, 8'hFF, 1'b1, 8'h0A);
        send(32'hBBBBBBBB, 4'hF, 1'b1, 8'h0B);
`endif
        idle_in();
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
